// File: rtl/burst_cycle_sequencer_if.sv
// Handshake/status bundle between the burst control registers and the burst cycle sequencer.
// The control side drives enable, trigger, carrier wrap and the burst programming;
// the sequencer returns the gate enable and burst status.
interface burst_cycle_sequencer_if #(
    parameter int CNT_W  = 20,
    parameter int HOLD_W = 16
);
    logic              Burst_EN;
    logic              Trig_In;
    logic              Cycle_Wrap;
    logic [CNT_W-1:0]  Cycle_Count;
    logic [HOLD_W-1:0] Holdoff_Value;
    logic              Gate_Out;
    logic              Busy;
    logic [CNT_W-1:0]  Count_Out;
    logic              Done_Pulse;
    logic              Missed_Trig;

    modport master (
        output Burst_EN,
        output Trig_In,
        output Cycle_Wrap,
        output Cycle_Count,
        output Holdoff_Value,
        input  Gate_Out,
        input  Busy,
        input  Count_Out,
        input  Done_Pulse,
        input  Missed_Trig
    );

    modport slave (
        input  Burst_EN,
        input  Trig_In,
        input  Cycle_Wrap,
        input  Cycle_Count,
        input  Holdoff_Value,
        output Gate_Out,
        output Busy,
        output Count_Out,
        output Done_Pulse,
        output Missed_Trig
    );
endinterface

// File: rtl/burst_cycle_sequencer.sv
// Burst cycle sequencer: after a synchronised trigger edge, gates the waveform output for
// N carrier cycles (counted on DDS wrap pulses), then waits a programmable holdoff before
// accepting the next trigger. N = 0 gates until burst mode is disabled.
// All outputs are registered; SYNC_STAGES must be at least 2.
module burst_cycle_sequencer #(
    parameter int CNT_W       = 20,
    parameter int HOLD_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   Clock,
    input  logic                   Reset,
    burst_cycle_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_RUN     = 2'd2,
        S_HOLDOFF = 2'd3
    } state_t;

    state_t                 state_q, state_d;

    // Trigger synchroniser (bit 0 is the newest sample) and edge-detect history
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   trig_prev_q, trig_prev_d;
    logic                   trig_rise;

    // Burst bookkeeping
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       n_lat_q, n_lat_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   burst_last;

    // Registered outputs
    logic                   gate_q, gate_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   missed_q, missed_d;

    // A state in which a new trigger cannot be accepted
    function automatic logic is_busy(input state_t s);
        return (s == S_RUN) || (s == S_HOLDOFF);
    endfunction

    // Shift the asynchronous trigger through the synchroniser and remember the last synced level
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], bus.Trig_In};
        trig_prev_d = sync_q[SYNC_STAGES-1];
    end

    // Rising edge of the synchronised trigger; both operands come straight from flops
    assign trig_rise = sync_q[SYNC_STAGES-1] & ~trig_prev_q;

    // This wrap completes the burst (never true for an infinite burst, N_lat = 0)
    assign burst_last = bus.Cycle_Wrap && (n_lat_q != '0) &&
                        (count_q == n_lat_q - CNT_W'(1));

    // Next-state decode; dropping Burst_EN aborts from any state
    always_comb begin
        state_d = state_q;
        if (!bus.Burst_EN) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_ARMED;
                S_ARMED:   if (trig_rise) state_d = S_RUN;
                S_RUN:     if (burst_last) state_d = S_HOLDOFF;
                S_HOLDOFF: if (hold_q == '0) state_d = S_ARMED;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Output and counter updates for the coming state; an abort leaves Count_Out untouched
    always_comb begin
        count_d  = count_q;
        n_lat_d  = n_lat_q;
        hold_d   = hold_q;
        done_d   = 1'b0;
        missed_d = 1'b0;
        gate_d   = (state_d == S_RUN);
        busy_d   = is_busy(state_d);

        if (bus.Burst_EN) begin
            case (state_q)
                S_ARMED: begin
                    // A wrap landing on the trigger clock belongs to the previous
                    // carrier cycle, so the count starts from zero here.
                    if (trig_rise) begin
                        n_lat_d = bus.Cycle_Count;
                        count_d = '0;
                    end
                end
                S_RUN: begin
                    missed_d = trig_rise;
                    if (bus.Cycle_Wrap) begin
                        // Free-running wrap for N_lat = 0; otherwise stops at N_lat
                        count_d = count_q + CNT_W'(1);
                        if (burst_last) begin
                            done_d = 1'b1;
                            hold_d = bus.Holdoff_Value;
                        end
                    end
                end
                S_HOLDOFF: begin
                    missed_d = trig_rise;
                    if (hold_q != '0) begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                default: begin
                    // IDLE ignores triggers silently
                end
            endcase
        end
    end

    // Control flops: state, synchroniser and every output, cleared by reset
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            sync_q      <= '0;
            trig_prev_q <= 1'b0;
            count_q     <= '0;
            gate_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            missed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            trig_prev_q <= trig_prev_d;
            count_q     <= count_d;
            gate_q      <= gate_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            missed_q    <= missed_d;
        end
    end

    // Latched burst length and holdoff counter: always loaded before being read
    always_ff @(posedge Clock) begin
        n_lat_q <= n_lat_d;
        hold_q  <= hold_d;
    end

    assign bus.Gate_Out    = gate_q;
    assign bus.Busy        = busy_q;
    assign bus.Count_Out   = count_q;
    assign bus.Done_Pulse  = done_q;
    assign bus.Missed_Trig = missed_q;

endmodule

// File: tb/tb_burst_cycle_sequencer.sv
// Bench for burst_cycle_sequencer: directed burst scenarios followed by random traffic,
// every clock compared against a burst-level reference model.
`timescale 1ns/1ps
module tb_burst_cycle_sequencer;

    // A narrow count so that an infinite burst wraps Count_Out within a short run
    localparam int CNT_W       = 16;
    localparam int HOLD_W      = 16;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_MOD     = 1 << CNT_W;
    localparam int TIN_DEPTH   = 100000;

    logic Clock = 1'b0;
    logic Reset = 1'b0;

    burst_cycle_sequencer_if #(.CNT_W(CNT_W), .HOLD_W(HOLD_W)) bus ();

    burst_cycle_sequencer #(
        .CNT_W      (CNT_W),
        .HOLD_W     (HOLD_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Trigger level seen at each clock edge (zero where reset flushes the synchroniser)
    bit tin_hist [0:TIN_DEPTH-1];

    // Reference model: burst-level view
    bit m_ready, m_firing, m_cooling, m_done, m_missed;
    int m_cnt, m_n, m_cool_left;

    // Observed tallies for scenario checks
    int gate_cycles, done_seen, missed_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_edge(input bit rst_n, input bit en, input bit wrap,
                              input int ncfg, input int hval, input bit rise);
        m_done   = 1'b0;
        m_missed = 1'b0;
        if (!rst_n) begin
            m_ready = 0; m_firing = 0; m_cooling = 0; m_cnt = 0;
        end else if (!en) begin
            m_ready = 0; m_firing = 0; m_cooling = 0;
        end else if (m_firing) begin
            m_missed = rise;
            if (wrap) begin
                m_cnt = (m_cnt + 1) % CNT_MOD;
                if (m_n != 0 && m_cnt == m_n) begin
                    m_firing    = 0;
                    m_cooling   = 1;
                    m_cool_left = hval + 1;   // holdoff spans Holdoff_Value+1 clocks
                    m_done      = 1;
                end
            end
        end else if (m_cooling) begin
            m_missed = rise;
            m_cool_left--;
            if (m_cool_left == 0) begin
                m_cooling = 0;
                m_ready   = 1;
            end
        end else if (m_ready) begin
            if (rise) begin
                m_firing = 1; m_ready = 0; m_n = ncfg; m_cnt = 0;
            end
        end else begin
            m_ready = 1;
        end
    endtask

    task automatic step();
        bit rise;
        @(posedge Clock);
        cyc++;
        if (cyc >= TIN_DEPTH) begin
            $display("FAIL cycle_budget: observed %0d cycles, limit %0d", cyc, TIN_DEPTH);
            $fatal(1, "cycle budget exhausted");
        end
        tin_hist[cyc] = bus.Trig_In;
        if (!Reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) tin_hist[cyc-i] = 1'b0;
        end
        rise = (cyc > SYNC_STAGES) && tin_hist[cyc-SYNC_STAGES] && !tin_hist[cyc-SYNC_STAGES-1];
        model_edge(Reset, bus.Burst_EN, bus.Cycle_Wrap, int'(bus.Cycle_Count),
                   int'(bus.Holdoff_Value), rise);
        #1;
        check("gate",   32'(bus.Gate_Out),    32'(m_firing));
        check("busy",   32'(bus.Busy),        32'(m_firing || m_cooling));
        check("count",  32'(bus.Count_Out),   32'(m_cnt));
        check("done",   32'(bus.Done_Pulse),  32'(m_done));
        check("missed", 32'(bus.Missed_Trig), 32'(m_missed));
        if (bus.Gate_Out)    gate_cycles++;
        if (bus.Done_Pulse)  done_seen++;
        if (bus.Missed_Trig) missed_seen++;
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_tally();
        gate_cycles = 0; done_seen = 0; missed_seen = 0;
    endtask

    task automatic pulse_trig();
        bus.Trig_In = 1'b1;
        step();
        bus.Trig_In = 1'b0;
    endtask

    task automatic wrap_cycle();
        run_steps(4);
        bus.Cycle_Wrap = 1'b1;
        step();
        bus.Cycle_Wrap = 1'b0;
    endtask

    initial begin
        int lat;
        int wraps;

        bus.Burst_EN      = 1'b0;
        bus.Trig_In       = 1'b0;
        bus.Cycle_Wrap    = 1'b0;
        bus.Cycle_Count   = CNT_W'(3);
        bus.Holdoff_Value = HOLD_W'(5);
        m_ready = 0; m_firing = 0; m_cooling = 0; m_cnt = 0; m_n = 0; m_cool_left = 0;
        clr_tally();

        // Reset held three clocks while the inputs toggle
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.Trig_In    = ~bus.Trig_In;
            bus.Cycle_Wrap = ~bus.Cycle_Wrap;
            bus.Burst_EN   = ~bus.Burst_EN;
            step();
        end
        check("rst_gate",   32'(bus.Gate_Out),    0);
        check("rst_busy",   32'(bus.Busy),        0);
        check("rst_count",  32'(bus.Count_Out),   0);
        check("rst_done",   32'(bus.Done_Pulse),  0);
        check("rst_missed", 32'(bus.Missed_Trig), 0);
        Reset          = 1'b1;
        bus.Burst_EN   = 1'b0;
        bus.Trig_In    = 1'b0;
        bus.Cycle_Wrap = 1'b0;
        run_steps(4);

        // N=3, holdoff 5, wraps every 10 clocks
        bus.Cycle_Count   = CNT_W'(3);
        bus.Holdoff_Value = HOLD_W'(5);
        bus.Burst_EN      = 1'b1;
        run_steps(3);
        clr_tally();
        bus.Trig_In = 1'b1;
        lat = 0;
        while (!bus.Gate_Out && lat < 10) begin
            step();
            lat++;
        end
        check("t2_gate_latency", 32'(lat), 32'(SYNC_STAGES + 1));
        bus.Trig_In = 1'b0;
        wraps = 0;
        while (done_seen == 0 && wraps < 10) begin
            run_steps(9);
            bus.Cycle_Wrap = 1'b1;
            step();
            bus.Cycle_Wrap = 1'b0;
            wraps++;
        end
        check("t2_wraps",     32'(wraps),         3);
        check("t2_count_out", 32'(bus.Count_Out), 3);
        check("t2_gate_fell", 32'(bus.Gate_Out),  0);
        lat = 0;
        while (bus.Busy && lat < 30) begin
            step();
            lat++;
        end
        check("t2_rearm_clocks", 32'(lat),       5 + 1);
        check("t2_done_pulses",  32'(done_seen), 1);

        // N=1, holdoff 0, wrap on the trigger-latch clock is not counted
        bus.Cycle_Count   = CNT_W'(1);
        bus.Holdoff_Value = HOLD_W'(0);
        run_steps(2);
        clr_tally();
        bus.Trig_In = 1'b1;
        run_steps(SYNC_STAGES);
        bus.Cycle_Wrap = 1'b1;
        step();
        bus.Cycle_Wrap = 1'b0;
        bus.Trig_In    = 1'b0;
        check("t3_gate_on",  32'(bus.Gate_Out),  1);
        check("t3_count_0",  32'(bus.Count_Out), 0);
        run_steps(4);
        check("t3_still_on", 32'(bus.Gate_Out),  1);
        bus.Cycle_Wrap = 1'b1;
        step();
        bus.Cycle_Wrap = 1'b0;
        check("t3_gate_off", 32'(bus.Gate_Out),  0);
        check("t3_count_1",  32'(bus.Count_Out), 1);
        run_steps(3);
        check("t3_rearmed",  32'(bus.Busy),      0);

        // N=4, holdoff 20, extra triggers during RUN and HOLDOFF
        bus.Cycle_Count   = CNT_W'(4);
        bus.Holdoff_Value = HOLD_W'(20);
        clr_tally();
        pulse_trig();
        run_steps(3);
        wrap_cycle();
        wrap_cycle();
        pulse_trig();
        run_steps(3);
        wrap_cycle();
        wrap_cycle();
        run_steps(2);
        pulse_trig();
        run_steps(3);
        check("t4_in_holdoff", 32'(bus.Busy), 1);
        run_steps(25);
        check("t4_missed",    32'(missed_seen),   2);
        check("t4_done",      32'(done_seen),     1);
        check("t4_count_out", 32'(bus.Count_Out), 4);
        check("t4_rearmed",   32'(bus.Busy),      0);

        // N=0: infinite burst, Count_Out wraps, abort on Burst_EN drop
        bus.Cycle_Count   = CNT_W'(0);
        bus.Holdoff_Value = HOLD_W'(0);
        pulse_trig();
        run_steps(3);
        check("t5_gate_on", 32'(bus.Gate_Out), 1);
        clr_tally();
        bus.Cycle_Wrap = 1'b1;
        run_steps(70000);
        bus.Cycle_Wrap = 1'b0;
        check("t5_gate_held",  32'(gate_cycles),   70000);
        check("t5_count_wrap", 32'(bus.Count_Out), 32'(70000 % CNT_MOD));
        bus.Burst_EN = 1'b0;
        step();
        check("t5_abort_gate",  32'(bus.Gate_Out),  0);
        check("t5_abort_busy",  32'(bus.Busy),      0);
        check("t5_abort_done",  32'(done_seen),     0);
        check("t5_count_holds", 32'(bus.Count_Out), 32'(70000 % CNT_MOD));

        // Cycle_Count changed 5 -> 2 mid-burst
        bus.Burst_EN      = 1'b1;
        bus.Cycle_Count   = CNT_W'(5);
        bus.Holdoff_Value = HOLD_W'(2);
        run_steps(2);
        pulse_trig();
        run_steps(3);
        clr_tally();
        wrap_cycle();
        bus.Cycle_Count = CNT_W'(2);
        wraps = 1;
        while (done_seen == 0 && wraps < 12) begin
            wrap_cycle();
            wraps++;
        end
        check("t6_first_wraps", 32'(wraps),         5);
        check("t6_first_count", 32'(bus.Count_Out), 5);
        run_steps(6);
        clr_tally();
        pulse_trig();
        run_steps(3);
        wraps = 0;
        while (done_seen == 0 && wraps < 12) begin
            wrap_cycle();
            wraps++;
        end
        check("t6_second_wraps", 32'(wraps),         2);
        check("t6_second_count", 32'(bus.Count_Out), 2);

        // Random traffic, including occasional reset and enable drops
        for (int i = 0; i < 3000; i++) begin
            Reset          = ($urandom_range(0, 499) != 0);
            bus.Burst_EN   = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 5) == 0) bus.Trig_In = ~bus.Trig_In;
            bus.Cycle_Wrap = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) bus.Cycle_Count   = CNT_W'($urandom_range(0, 5));
            if ($urandom_range(0, 49) == 0) bus.Holdoff_Value = HOLD_W'($urandom_range(0, 7));
            step();
        end
        Reset = 1'b1;
        run_steps(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
